video_pattern_gen: RTL and testbench

- Synthesizable video timing and test-pattern source; drives the vsync/hsync/de/24-bit RGB stream consumed by the BMP capture sink and by the stitching datapath under test.
- Generates raster timing from parameterised porches and syncs.
- Fills the active area with one of four selectable patterns.
- Provides a frame counter and a frame-done pulse for bench sequencing.

---
 rtl/video_pattern_gen.sv | 113 +++++++++++
 tb/tb_video_pattern_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing generator with four selectable test patterns,
// frame counter and frame-done pulse.
module video_pattern_gen #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            pattern_sel,
    input  logic [23:0]           solid_rgb,
    output logic                  video_vsync,
    output logic                  video_hsync,
    output logic                  video_de,
    output logic [DATA_WIDTH-1:0] video_data,
    output logic [15:0]           frame_cnt,
    output logic                  frame_done
);
    localparam logic [15:0] HT  = 16'(H_SYNC + H_BACK + IMG_HDISP + H_FRONT);
    localparam logic [15:0] HAS = 16'(H_SYNC + H_BACK);
    localparam logic [15:0] HAE = 16'(H_SYNC + H_BACK + IMG_HDISP);
    localparam logic [15:0] HS  = 16'(H_SYNC);
    localparam logic [15:0] VT  = 16'(V_SYNC + V_BACK + IMG_VDISP + V_FRONT);
    localparam logic [15:0] VAS = 16'(V_SYNC + V_BACK);
    localparam logic [15:0] VAE = 16'(V_SYNC + V_BACK + IMG_VDISP);
    localparam logic [15:0] VS  = 16'(V_SYNC);
    localparam logic [15:0] BW  = 16'(IMG_HDISP / 8);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [15:0] h_cnt, v_cnt, bar_sub;
    logic [2:0]  bar;
    logic [1:0]  pat;
    logic [23:0] solid, bar_rgb, pix;
    logic [7:0]  x;
    logic        y_bit3, active, h_end, v_end, bar_step;

    assign x        = 8'(h_cnt - HAS);
    assign y_bit3   = 1'((v_cnt - VAS) >> 3);
    assign active   = h_cnt >= HAS && h_cnt < HAE && v_cnt >= VAS && v_cnt < VAE;
    assign h_end    = h_cnt == HT - 16'd1;
    assign v_end    = v_cnt == VT - 16'd1;
    assign bar_step = h_cnt >= HAS && h_cnt < HAE - 16'd1;
    // Bar colours follow directly from the bar index bits.
    assign bar_rgb  = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};

    always_comb begin
        pix = pat == 2'd0 ? solid :
              pat == 2'd1 ? bar_rgb :
              pat == 2'd2 ? {3{x}} :
              {24{x[3] ^ y_bit3 ^ frame_cnt[0]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar         <= '0;
            bar_sub     <= '0;
            pat         <= '0;
            solid       <= '0;
            video_vsync <= 1'b0;
            video_hsync <= 1'b0;
            video_de    <= 1'b0;
            video_data  <= '0;
            frame_cnt   <= '0;
            frame_done  <= 1'b0;
        end else if (state == IDLE) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar         <= '0;
            bar_sub     <= '0;
            video_vsync <= 1'b0;
            video_hsync <= 1'b0;
            video_de    <= 1'b0;
            video_data  <= '0;
            frame_done  <= 1'b0;
            if (en) begin
                state <= RUN;
                pat   <= pattern_sel;
                solid <= solid_rgb;
            end
        end else begin
            video_hsync <= h_cnt < HS;
            video_vsync <= v_cnt < VS;
            video_de    <= active;
            video_data  <= active ? DATA_WIDTH'(pix) : '0;
            h_cnt       <= h_end ? '0 : h_cnt + 16'd1;
            if (h_end)
                v_cnt <= v_end ? '0 : v_cnt + 16'd1;
            // Bar index tracks x without a divider: sub-count resets outside the active span.
            bar_sub     <= !bar_step || bar_sub == BW - 16'd1 ? '0 : bar_sub + 16'd1;
            bar         <= !bar_step ? '0 : bar_sub == BW - 16'd1 ? bar + 3'd1 : bar;
            frame_done  <= h_end && v_end;
            if (h_end && v_end) begin
                frame_cnt <= frame_cnt + 16'd1;
                pat       <= pattern_sel;
                solid     <= solid_rgb;
                if (!en)
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: two small-raster instances checked every clock against a
// linear-position reference model, plus table-driven frame checks and corner sequences.
module tb_video_pattern_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic        en_i  [2];
    logic [1:0]  sel_i [2];
    logic [23:0] rgb_i [2];
    logic        vs_o [2], hs_o [2], de_o [2], fd_o [2];
    logic [23:0] d_o  [2];
    logic [15:0] fc_o [2];

    int HD [2] = '{8, 16};
    int VD [2] = '{4, 16};
    int HF [2] = '{1, 1};
    int HS [2] = '{2, 1};
    int HB [2] = '{1, 1};
    int VF [2] = '{1, 1};
    int VS [2] = '{1, 1};
    int VB [2] = '{1, 1};
    logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int compared = 0;
    int mismatched = 0;
    bit chk_on = 1'b0;

    video_pattern_gen #(.IMG_HDISP(8), .IMG_VDISP(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .DATA_WIDTH(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_i[0]), .pattern_sel(sel_i[0]), .solid_rgb(rgb_i[0]),
        .video_vsync(vs_o[0]), .video_hsync(hs_o[0]), .video_de(de_o[0]),
        .video_data(d_o[0]), .frame_cnt(fc_o[0]), .frame_done(fd_o[0]));

    video_pattern_gen #(.IMG_HDISP(16), .IMG_VDISP(16), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .DATA_WIDTH(24)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_i[1]), .pattern_sel(sel_i[1]), .solid_rgb(rgb_i[1]),
        .video_vsync(vs_o[1]), .video_hsync(hs_o[1]), .video_de(de_o[1]),
        .video_data(d_o[1]), .frame_cnt(fc_o[1]), .frame_done(fd_o[1]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one linear position per frame, decoded with division/modulo.
    typedef struct {
        bit          run;
        int          pos;
        logic [1:0]  pat;
        logic [23:0] rgb;
        logic [15:0] fc;
        logic        vs, hs, de, fd;
        logic [23:0] d;
    } model_t;
    model_t m [2];

    function automatic logic [23:0] pixel(input int i, input int x, input int y);
        case (m[i].pat)
            2'd0:    return m[i].rgb;
            2'd1:    return BARS[x / (HD[i] / 8)];
            2'd2:    return {3{8'(x % 256)}};
            default: return ((x / 8 + y / 8 + int'(m[i].fc)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
        endcase
    endfunction

    task automatic step(input int i);
        int ht, vt, h, v, x, y;
        ht = HS[i] + HB[i] + HD[i] + HF[i];
        vt = VS[i] + VB[i] + VD[i] + VF[i];
        if (!m[i].run) begin
            m[i].vs = 0; m[i].hs = 0; m[i].de = 0; m[i].fd = 0; m[i].d = '0;
            if (en_i[i]) begin
                m[i].run = 1; m[i].pos = 0; m[i].pat = sel_i[i]; m[i].rgb = rgb_i[i];
            end
        end else begin
            h = m[i].pos % ht;
            v = m[i].pos / ht;
            x = h - HS[i] - HB[i];
            y = v - VS[i] - VB[i];
            m[i].hs = h < HS[i];
            m[i].vs = v < VS[i];
            m[i].de = x >= 0 && x < HD[i] && y >= 0 && y < VD[i];
            m[i].d  = m[i].de ? pixel(i, x, y) : 24'h0;
            m[i].fd = m[i].pos == ht * vt - 1;
            if (m[i].fd) begin
                m[i].fc  = m[i].fc + 16'd1;
                m[i].pat = sel_i[i];
                m[i].rgb = rgb_i[i];
                m[i].pos = 0;
                if (!en_i[i]) m[i].run = 0;
            end else m[i].pos++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < 2; i++) m[i] = '{default: 0};
        else for (int i = 0; i < 2; i++) step(i);
    end

    always @(negedge clk) begin
        if (chk_on)
            for (int i = 0; i < 2; i++)
                chk($sformatf("stream%0d", i),
                    {vs_o[i], hs_o[i], de_o[i], fd_o[i], fc_o[i], d_o[i]},
                    {m[i].vs, m[i].hs, m[i].de, m[i].fd, m[i].fc, m[i].d});
    end

    // Frame capture and per-frame statistics.
    logic [23:0] capa [32], lasta [32], capb [256], lastb [256];
    int k_i [2], hsn [2], lastk [2], lasths [2], per [2], fdcyc [2], fdcnt [2];
    logic [15:0] exp_fc [2];
    int cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            k_i[0] = 0; k_i[1] = 0; hsn[0] = 0; hsn[1] = 0;
        end else for (int i = 0; i < 2; i++) begin
            if (de_o[i] === 1'b1) begin
                if (i == 0 && k_i[0] < 32) capa[k_i[0]] = d_o[0];
                if (i == 1 && k_i[1] < 256) capb[k_i[1]] = d_o[1];
                k_i[i]++;
            end
            if (hs_o[i] === 1'b1) hsn[i]++;
            if (fd_o[i] === 1'b1) begin
                if (i == 0) lasta = capa; else lastb = capb;
                lastk[i] = k_i[i]; lasths[i] = hsn[i];
                per[i] = cyc - fdcyc[i]; fdcyc[i] = cyc;
                k_i[i] = 0; hsn[i] = 0; fdcnt[i]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_fd(input int i, input int limit);
        int start, n;
        start = fdcnt[i];
        n = 0;
        while (fdcnt[i] == start && n < limit) begin
            tick(1);
            n++;
        end
        compared++;
        if (fdcnt[i] == start) begin
            mismatched++;
            $display("FAIL frame_done_timeout%0d: no pulse within %0d clocks", i, limit);
        end else exp_fc[i] = exp_fc[i] + 16'd1;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [23:0] rgb;
        logic [23:0] line [8];
    } vec_t;
    vec_t tbl [4];

    task automatic check_frame_a(input int r);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                chk($sformatf("row%0d_pix_%0d_%0d", r, x, y), lasta[y * 8 + x], tbl[r].line[x]);
    endtask

    initial begin
        tbl[0].sel = 2'd1; tbl[0].rgb = 24'h0;      tbl[0].line = BARS;
        tbl[1].sel = 2'd0; tbl[1].rgb = 24'h123456;
        tbl[2].sel = 2'd2; tbl[2].rgb = 24'h0;
        tbl[3].sel = 2'd0; tbl[3].rgb = 24'hABCDEF;
        for (int x = 0; x < 8; x++) begin
            tbl[1].line[x] = 24'h123456;
            tbl[2].line[x] = {3{8'(x)}};
            tbl[3].line[x] = 24'hABCDEF;
        end
        for (int i = 0; i < 2; i++) begin
            en_i[i] = 0; sel_i[i] = 0; rgb_i[i] = 0; exp_fc[i] = 0;
            fdcnt[i] = 0; fdcyc[i] = 0;
        end
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        tick(3);
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset%0d", i), {vs_o[i], hs_o[i], de_o[i], fd_o[i], fc_o[i], d_o[i]}, 64'h0);
        rst_n = 1'b1;
        tick(2);
        fork
            begin
                sel_i[0] = 2'd1; en_i[0] = 1'b1;
                tick(1);
                chk("vsync_before_rise", vs_o[0], 0);
                tick(1);
                chk("vsync_rise", vs_o[0], 1);
                chk("hsync_at_start", hs_o[0], 1);
                for (int r = 0; r < 4; r++) begin
                    tick(40);
                    sel_i[0] = tbl[r].sel; rgb_i[0] = tbl[r].rgb;
                    wait_fd(0, 200);
                    check_frame_a(r == 0 ? 0 : r - 1);
                    wait_fd(0, 200);
                    check_frame_a(r);
                    chk("frame_cnt_a", fc_o[0], exp_fc[0]);
                    if (r == 0) begin
                        chk("frame_period", per[0], 84);
                        chk("hsync_clocks_per_frame", lasths[0], 14);
                        chk("de_pixels_per_frame", lastk[0], 32);
                    end
                end
                tick(27);
                en_i[0] = 1'b0;
                wait_fd(0, 200);
                chk("de_pixels_after_en_drop", lastk[0], 32);
                chk("frame_cnt_at_stop", fc_o[0], exp_fc[0]);
                tick(150);
                chk("idle_outputs", {vs_o[0], hs_o[0], de_o[0], fd_o[0], d_o[0]}, 0);
                chk("idle_frame_cnt_hold", fc_o[0], exp_fc[0]);
                en_i[0] = 1'b1;
                tick(1);
                chk("restart_vsync_before", vs_o[0], 0);
                tick(1);
                chk("restart_vsync_rise", vs_o[0], 1);
            end
            begin
                sel_i[1] = 2'd3; en_i[1] = 1'b1;
                wait_fd(1, 800);
                chk("chk_f0_p0_0", lastb[0], 24'h000000);
                chk("chk_f0_p8_0", lastb[8], 24'hFFFFFF);
                chk("chk_f0_p0_8", lastb[128], 24'hFFFFFF);
                chk("chk_f0_p8_8", lastb[136], 24'h000000);
                chk("chk_frame_cnt1", fc_o[1], 16'd1);
                wait_fd(1, 800);
                chk("chk_f1_p0_0", lastb[0], 24'hFFFFFF);
                chk("chk_f1_p8_0", lastb[8], 24'h000000);
                chk("chk_frame_cnt2", fc_o[1], 16'd2);
            end
        join
        tick(50);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("async_reset%0d", i), {vs_o[i], hs_o[i], de_o[i], fd_o[i], fc_o[i], d_o[i]}, 64'h0);
        tick(2);
        rst_n = 1'b1;
        exp_fc[0] = 0;
        tick(5);
        chk("frame_cnt_after_reset", fc_o[0], 16'd0);
        wait_fd(0, 300);
        chk("frame_cnt_first_after_reset", fc_o[0], 16'd1);
        for (int n = 0; n < 30; n++) begin
            tick($urandom_range(1, 150));
            for (int i = 0; i < 2; i++) begin
                sel_i[i] = 2'($urandom);
                rgb_i[i] = 24'($urandom);
                en_i[i]  = $urandom_range(0, 4) != 0;
            end
        end
        en_i[0] = 1'b1; en_i[1] = 1'b1;
        tick(800);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
